// File: rtl/serial_pkg.sv
// Shared types and constants for the serial (UART) receive/transmit slice.
// Pure declarations: no logic, no latency, no flow control.
// Frame is 8N1, LSB first, idle-high line.
package serial_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } serial_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; resets to 1 (idle line level).
// Latency: 2 clk cycles from input change to q.
// No flow control.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// UART 8N1 receiver: mid-bit sampling, one rx_cplt or rx_error pulse per frame.
// Latency: pulse 2 + 1 + HALF + 9*CLKS_PER_BIT cycles after the start-bit falling edge at the pin.
// No backpressure: rx_data is overwritten by the next good frame whether consumed or not.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_cplt,
  output logic                 rx_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  logic rxs;

  serial_rx_state_t       state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [IDX_W-1:0]       idx_d, idx_q;
  logic [DATA_BITS-1:0]   shift_d, shift_q;
  logic [DATA_BITS-1:0]   rx_data_d, rx_data_q;
  logic                   rx_cplt_d, rx_cplt_q;
  logic                   rx_error_d, rx_error_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_cplt_d  = 1'b0;
    rx_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high here was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxs) begin
            rx_data_d = shift_q;
            rx_cplt_d = 1'b1;
            state_d   = IDLE;
          end else begin
            rx_error_d = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start bit.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_cplt_q  <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_cplt_q  <= rx_cplt_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_cplt  = rx_cplt_q;
  assign rx_error = rx_error_q;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboarded bench for serial_rx: frames are driven at the pin, the expected
// pulse (kind, byte, cycle) is queued at send time and matched by a monitor.
module tb_serial_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Pin edge -> 2 sync cycles -> IDLE detect edge -> HALF + 9 bit periods to stop sample.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_cplt;
  logic       rx_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] last_good;
  logic [7:0] prev_data;

  serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_cplt  (rx_cplt),
    .rx_error (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_cplt || rx_error) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got cplt=%0b err=%0b data=%02h at cyc %0d, required no pulse",
                   rx_cplt, rx_error, rx_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (rx_error !== mon_e.is_err || rx_cplt !== !mon_e.is_err ||
              rx_data !== mon_e.data || cyc != mon_e.cyc) begin
            failures++;
            $display("FAIL frame_pulse: got cplt=%0b err=%0b data=%02h cyc=%0d, required err=%0b data=%02h cyc=%0d",
                     rx_cplt, rx_error, rx_data, cyc, mon_e.is_err, mon_e.data, mon_e.cyc);
          end
        end
      end
      checks++;
      if (!rx_cplt && rx_data !== prev_data) begin
        failures++;
        $display("FAIL data_hold: got rx_data %02h without rx_cplt, required %02h", rx_data, prev_data);
      end
    end
    prev_data = rx_data;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic hold(input logic val, input int n);
    rx = val;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    exp_t e;
    e.is_err = !stop_ok;
    e.cyc    = cyc + LAT;
    if (stop_ok) last_good = b;
    e.data   = last_good;
    sb.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_ok, CPB);
    if (gap > 0) hold(1'b1, gap);
  endtask

  initial begin
    int r;
    last_good = 8'h00;
    rx        = 1'b1;
    rst_n     = 1'b0;
    #3;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_cplt", {7'd0, rx_cplt}, 8'h00);
    check("reset_rx_error", {7'd0, rx_error}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 3 * CPB);

    send_frame(8'hA5, 1'b1, 2 * CPB);

    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 2 * CPB);

    hold(1'b0, 4);
    hold(1'b1, 2 * CPB);
    send_frame(8'h3C, 1'b1, 2 * CPB);

    send_frame(8'h55, 1'b0, 0);
    hold(1'b0, 40);
    hold(1'b1, 2 * CPB);
    send_frame(8'h12, 1'b1, 2 * CPB);

    // Break: reads as an all-zero frame with a bad stop bit, then stays low.
    send_frame(8'h00, 1'b0, 0);
    hold(1'b0, 20 * CPB);
    hold(1'b1, 2 * CPB);
    send_frame(8'hC3, 1'b1, 2 * CPB);

    // Abort 8'h81 half-way through data bit 4.
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(i == 0, CPB);
    hold(1'b0, HALF);
    rst_n = 1'b0;
    #1;
    check("async_rst_rx_data", rx_data, 8'h00);
    check("async_rst_rx_cplt", {7'd0, rx_cplt}, 8'h00);
    check("async_rst_rx_error", {7'd0, rx_error}, 8'h00);
    last_good = 8'h00;
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 2 * CPB);
    send_frame(8'h81, 1'b1, 2 * CPB);

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        hold(1'b0, $urandom_range(1, HALF - 2));
        hold(1'b1, 2 * CPB);
      end else if (r < 4) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 0);
        hold(1'b0, $urandom_range(0, 30));
        hold(1'b1, CPB + $urandom_range(0, 10));
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 20));
      end
    end

    hold(1'b1, 4 * CPB);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d expected pulses never seen, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- UART receiver that turns the asynchronous serial line into the byte stream consumed by the init/loader block.
- Produces a byte, a 1-cycle completion pulse and a 1-cycle error pulse per frame.
- Frame format: 8N1, LSB first, line idles high.
- Sits between the board RX pin and the command FSM's serial_data_in/serial_in_cplt/serial_in_error inputs.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Legal range is >= 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8 for this design.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- rx  input  1  raw asynchronous serial line.
- rx_data  output  8  last correctly received byte.
- rx_cplt  output  1  1-cycle pulse: rx_data holds a new valid byte.
- rx_error  output  1  1-cycle pulse: framing error on the current frame.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - rx_data = 8'h00, rx_cplt = 0, rx_error = 0.
  - Both synchronizer flops = 1.
  - state = IDLE; bit counter and clock counter = 0.
- Synchronizer: rx passes through a 2-flop synchronizer. All logic below uses the synchronized value rxs.
- Clock counter: width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, integer division.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On rxs == 0: go to START with clock counter = 0.
- START:
  - Count up. When counter == HALF-1, sample rxs.
  - If rxs == 0: go to DATA, counter = 0, bit index = 0.
  - If rxs == 1: treat as a glitch. Go to IDLE with no pulse on either output.
- DATA:
  - Count up. When counter == CLKS_PER_BIT-1, shift rxs into shift[bit index] (LSB first), reset counter, increment bit index.
  - After bit 7 is sampled, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rxs.
  - If rxs == 1: rx_data <= shift, rx_cplt <= 1 for exactly one cycle, go to IDLE.
  - If rxs == 0: rx_error <= 1 for exactly one cycle, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxs == 1, then go to IDLE.
  - A line held low (break) therefore produces exactly one error pulse and never re-triggers.
- Timing:
  - Stop-bit sample edge is HALF + 9*CLKS_PER_BIT cycles after the edge that detected rxs low in IDLE.
  - rx_cplt/rx_error are high in the following cycle.
  - Pin-to-detection adds 2 cycles of synchronizer delay.
- Back-to-back frames: the start bit of the next frame may begin on the cycle after the stop-bit sample. IDLE detects it with no lost cycle beyond the IDLE state itself.
- rx_cplt and rx_error are never both 1 in the same cycle.
- rx_data changes only in the cycle rx_cplt rises. It holds otherwise.
- No backpressure: the consumer samples rx_data on rx_cplt. An unconsumed byte is overwritten silently.
- Reset mid-frame aborts the frame, with all outputs and state back to reset values. The partial frame produces no pulse.

Decomposition:
- Package serial_pkg holds:
  - the state enum serial_rx_state_t (logic [2:0]);
  - the default constant CLKS_PER_BIT_DEFAULT = 434;
  - the frame constant DATA_BITS = 8.
- One sub-module, sync_2ff: a parameterless 1-bit two-flop synchronizer with async active-low reset to 1.
  - It is reused later by the transmit side and by the button inputs.

Test Plan (CLKS_PER_BIT = 16 for simulation):
- Send 8'hA5 with a valid stop bit, idle high before and after -> exactly one rx_cplt pulse and rx_data = 8'hA5. rx_error stays 0. The pulse appears 8 + 144 + 1 cycles after synchronized start detection.
- Send 8'h00 then 8'hFF back-to-back with no idle gap -> two rx_cplt pulses, carrying 8'h00 then 8'hFF, with no error.
- Drive rx low for 4 cycles (below HALF = 8), then high, then send 8'h3C -> no pulse for the glitch, then one rx_cplt with rx_data = 8'h3C.
- Send 8'h55 with stop bit 0, hold rx low for 40 cycles, release high, then send 8'h12:
  - one rx_error pulse, rx_data still the previous value, no rx_cplt;
  - then one rx_cplt with 8'h12.
- Hold rx low for 3 full frame times (break) -> exactly one rx_error pulse. After rx returns high, 8'hC3 is received correctly.
- Assert rst_n low during data bit 4 of 8'h81, then release with rx high:
  - outputs are 0 immediately (async) and no pulse follows from the aborted frame;
  - the next frame 8'h81 yields rx_cplt with rx_data = 8'h81.
